pt_stream_framer: RTL

//   Word-level front/back end for the ChaCha20 toy encrypter datapath (main).
//   - Accepts a plaintext word over a valid/ready handshake.
//   - Loads the keystream counter with a one-cycle lock pulse.
//   - Serialises the word one bit per clk onto the two-wire plaintext encoding.
//   - Collects the returned ciphertext bit each cycle into a word, offered downstream with valid/ready.

---
 rtl/chacha_toy_pkg.sv | 12 +
 rtl/pt_bit_shifter.sv | 42 ++++
 rtl/pt_stream_framer.sv | 70 +++++++
 3 files changed

// File: rtl/chacha_toy_pkg.sv
// chacha_toy_pkg: shared framer state codes, two-wire plaintext encoding and counter width.
package chacha_toy_pkg;
  localparam int CTR_W = 2;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_LOAD  = 2'd1;
  localparam state_t S_SHIFT = 2'd2;
  localparam state_t S_HOLD  = 2'd3;
  localparam logic [1:0] PT_IDLE = 2'b00;
  localparam logic [1:0] PT_ONE  = 2'b10;
  localparam logic [1:0] PT_ZERO = 2'b01;
endpackage

// File: rtl/pt_bit_shifter.sv
// pt_bit_shifter: holds the captured word, walks the bit index and collects ciphertext bits in place.
module pt_bit_shifter
  import chacha_toy_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int IW = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ct_bit_i,
  output logic              bit_o,
  output logic              last_o,
  output logic [DATA_W-1:0] out_data_o
);
  localparam logic [IW-1:0] FIRST = MSB_FIRST ? IW'(DATA_W-1) : '0;
  localparam logic [IW-1:0] LAST  = MSB_FIRST ? '0 : IW'(DATA_W-1);
  logic [DATA_W-1:0] word_q, ct_q;
  logic [IW-1:0]     idx_q;
  assign bit_o      = word_q[idx_q];
  assign last_o     = idx_q == LAST;
  assign out_data_o = ct_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      ct_q   <= '0;
      idx_q  <= '0;
    end else begin
      if (load_i) begin
        word_q <= data_i;
        idx_q  <= FIRST;
      end
      if (step_i) begin
        ct_q[idx_q] <= ct_bit_i;
        idx_q       <= last_o ? idx_q : MSB_FIRST ? idx_q - IW'(1) : idx_q + IW'(1);
      end
    end
  end
endmodule

// File: rtl/pt_stream_framer.sv
// pt_stream_framer: serialises plaintext words onto the two-wire encoding and reassembles ciphertext words.
module pt_stream_framer
  import chacha_toy_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTR_W-1:0]  in_start_ctr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pt_one,
  output logic              pt_zero,
  output logic              ks_lock,
  output logic [CTR_W-1:0]  ks_init_value,
  input  logic              ct_bit,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  state_t           state_q, state_d;
  logic             rdy_q, lock_q;
  logic [CTR_W-1:0] ctr_q;
  logic             acc, cur_bit, last;
  assign acc           = in_valid & in_ready;
  assign ks_lock       = lock_q;
  assign ks_init_value = ctr_q;
  pt_bit_shifter #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_shift (
    .clk        (clk),
    .reset      (reset),
    .load_i     (acc),
    .step_i     (state_q == S_SHIFT),
    .data_i     (in_data),
    .ct_bit_i   (ct_bit),
    .bit_o      (cur_bit),
    .last_o     (last),
    .out_data_o (out_data)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == S_IDLE  && acc)       ? S_LOAD  :
              (state_q == S_LOAD)               ? S_SHIFT :
              (state_q == S_SHIFT && last)      ? S_HOLD  :
              (state_q == S_HOLD  && out_ready) ? S_IDLE  : state_q;
  end
  always_comb begin
    in_ready          = rdy_q && state_q == S_IDLE;
    out_valid         = state_q == S_HOLD;
    busy              = state_q != S_IDLE;
    {pt_one, pt_zero} = state_q != S_SHIFT ? PT_IDLE : cur_bit ? PT_ONE : PT_ZERO;
  end
  // rdy_q keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q  <= 1'b0;
      lock_q <= 1'b0;
      ctr_q  <= '0;
    end else begin
      rdy_q  <= 1'b1;
      lock_q <= acc;
      ctr_q  <= acc ? in_start_ctr : ctr_q;
    end
  end
endmodule
